// File: rtl/ram_master.sv
// ram_master: sequences single or burst RAM writes and reads on behalf of a host.
// Writes fill consecutive addresses with one latched data word. Reads return one
// beat at a time through a valid/ready response channel.
// Optional feature: define RAM_MASTER_BURST_EN to honour req_len (req_len+1 beats);
// otherwise every request is a single beat and no beat counter is built.
module ram_master #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  wr_done,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wr_rd,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdAddr,
    StRdCap,
    StRspWait
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  wr_done_q, wr_done_d;
  logic                  accept;
  logic                  advance;
  logic                  last_beat;

`ifdef RAM_MASTER_BURST_EN
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;

  assign last_beat = (cnt_q == '0);

  // Beat counter: loads beats-minus-one on accept, counts down per completed beat.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = req_len;
    end else if (advance) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Beat counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Single-beat build: every beat is the last one and req_len is not used.
  assign last_beat = 1'b1;
  logic unused_beat;
  assign unused_beat = ^{req_len, accept, advance};
`endif

  // Next-state logic; the address is only bumped when another beat follows, so
  // ram_addr keeps showing the last address used once the burst ends.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wr_done_d = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept  = 1'b1;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = req_wr ? StWr : StRdAddr;
        end
      end
      StWr: begin
        if (last_beat) begin
          wr_done_d = 1'b1;
          state_d   = StIdle;
        end else begin
          advance = 1'b1;
          addr_d  = addr_q + 1'b1;
        end
      end
      StRdAddr: begin
        state_d = StRdCap;
      end
      StRdCap: begin
        rdata_d = ram_data_out;
        state_d = StRspWait;
      end
      StRspWait: begin
        if (rsp_ready) begin
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            advance = 1'b1;
            addr_d  = addr_q + 1'b1;
            state_d = StRdAddr;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any burst at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wr_done_q <= wr_done_d;
    end
  end

  // Outputs decoded from the state so reset forces them idle without a clock.
  always_comb begin
    req_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    rsp_valid = (state_q == StRspWait);
    rsp_rdata = rdata_q;
    wr_done   = wr_done_q;
    ram_addr  = addr_q;
    ram_wr_rd = (state_q == StWr);
    ram_data  = (state_q == StWr) ? wdata_q : '0;
  end

endmodule

// File: doc/ram_master.md
RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, the RAM address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, the RAM data width.
REQ-003 The block SHALL have parameter LEN_WIDTH, default 4, the burst length field width.
REQ-004 The block SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port req_valid  input  1  host request valid.
REQ-007 The block SHALL have port req_ready  output  1  block accepts request.
REQ-008 The block SHALL have port req_wr  input  1  1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr  input  ADDR_WIDTH  start address.
REQ-010 The block SHALL have port req_wdata  input  DATA_WIDTH  write fill data.
REQ-011 The block SHALL have port req_len  input  LEN_WIDTH  beats minus one.
REQ-012 The block SHALL have port rsp_valid  output  1  read data valid.
REQ-013 The block SHALL have port rsp_ready  input  1  host accepts read data.
REQ-014 The block SHALL have port rsp_rdata  output  DATA_WIDTH  read data.
REQ-015 The block SHALL have port wr_done  output  1  one-cycle pulse after the last write beat.
REQ-016 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 The block SHALL have port ram_addr  output  ADDR_WIDTH  to RAM addr.
REQ-018 The block SHALL have port ram_data  output  DATA_WIDTH  to RAM data.
REQ-019 The block SHALL have port ram_wr_rd  output  1  to RAM wr_rd: 1 = write, 0 = read.
REQ-020 The block SHALL have port ram_data_out  input  DATA_WIDTH  from the RAM registered read output, valid one cycle after the read edge.

Function
REQ-021 The FSM SHALL use states IDLE, WR, RD_ADDR, RD_CAP and RSP_WAIT.
REQ-022 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1, latching addr, wdata, len and wr.
REQ-023 On an accepted request, IDLE SHALL go to WR if req_wr=1, else to RD_ADDR; the beat counter loads req_len.
REQ-024 In WR: ram_wr_rd=1, ram_addr=current address, ram_data=latched wdata; one beat per cycle; address +1 and counter -1 per beat.
REQ-025 After the WR beat with counter=0, the FSM SHALL go to IDLE and assert wr_done for exactly one cycle, in the first IDLE cycle.
REQ-026 In RD_ADDR: ram_wr_rd=0, ram_addr=current address; next state RD_CAP.
REQ-027 In RD_CAP, ram_data_out SHALL be loaded into rsp_rdata with rsp_valid set to 1; next state RSP_WAIT.
REQ-028 In RSP_WAIT, rsp_valid and rsp_rdata SHALL hold stable until rsp_ready=1; on handshake the state goes to IDLE if counter=0, else RD_ADDR with address +1 and counter -1.
REQ-029 In IDLE, RD_CAP and RSP_WAIT: ram_wr_rd=0 and ram_data=0; ram_addr holds its last value.
REQ-030 The address increment SHALL wrap modulo 2^ADDR_WIDTH; for example 0xFF+1 becomes 0x00 with no error.
REQ-031 Minimum read latency SHALL be 2 cycles from the acceptance edge to rsp_valid=1, and each read beat SHALL take at least 3 cycles.
REQ-032 A write SHALL never be issued while a read response is pending, and a new request SHALL never be accepted while busy=1.

Reset
REQ-033 While rst=1 the block SHALL be in IDLE with req_ready=1, rsp_valid=0, rsp_rdata=0, wr_done=0, busy=0, ram_addr=0, ram_data=0 and ram_wr_rd=0.
REQ-034 A reset asserted mid-burst SHALL abort the burst immediately, discard remaining beats and any pending response, and issue no further RAM write.

Configuration
REQ-035 With macro RAM_MASTER_BURST_EN defined, req_len SHALL be honoured, giving req_len+1 beats per request.
REQ-036 Without RAM_MASTER_BURST_EN, req_len SHALL be ignored, every request SHALL be a single beat, and the beat counter logic SHALL be absent.

Verification
REQ-037 Single write: write addr 0x10, wdata 0xA5, len 0 -> one cycle with ram_wr_rd=1, ram_addr 0x10, ram_data 0xA5; wr_done pulse on the next cycle.
REQ-038 Single read: read addr 0x10 after REQ-037, rsp_ready=1 -> rsp_valid=1 with rsp_rdata 0xA5 two cycles after acceptance.
REQ-039 Burst fill with wrap (BURST_EN): write addr 0xFE, wdata 0x3C, len 3 -> 0xFE, 0xFF, 0x00 and 0x01 written 0x3C on consecutive cycles; a 4-beat read returns four 0x3C values.
REQ-040 Backpressure: read burst len 1 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable; no second RAM read until the handshake.
REQ-041 Reset mid-burst: assert rst during beat 2 of a len-7 write -> outputs take their reset values at once, no further writes occur, and req_ready=1 after release.
REQ-042 Burst disabled: write len 5 with the macro undefined -> exactly one write beat and wr_done pulse.
